// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) feeding alu_op and datapath enables.
// Optional: ILLEGAL_TRAP_EN traps illegal instructions into a sticky HALT state.
`timescale 1ns/1ps

module multicycle_ctrl #(
    parameter logic [3:0] ALU_AND  = 4'b0000,
    parameter logic [3:0] ALU_OR   = 4'b0001,
    parameter logic [3:0] ALU_ADD  = 4'b0010,
    parameter logic [3:0] ALU_SUB  = 4'b0110,
    parameter logic [3:0] ALU_LESS = 4'b0111,
    parameter logic [3:0] ALU_LR   = 4'b1000,
    parameter logic [3:0] ALU_LL   = 4'b1001,
    parameter logic [3:0] ALU_NR   = 4'b1010,
    parameter logic [3:0] ALU_XOR  = 4'b1101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        illegal
);

    // IF fetch | ID decode | EX execute/branch | MEM data access | WB writeback | HALT trapped
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LW = 3'd2,
        CLS_SW = 3'd3,
        CLS_BR = 3'd4
    } cls_t;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       illegal_q, illegal_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [3:0] arith_op, dec_op;
    cls_t       dec_cls;
    logic       dec_ill;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_LL;
            3'b010:  arith_op = ALU_LESS;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = (funct7 == F7_ALT) ? ALU_NR : ALU_LR;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    end

    always_comb begin
        dec_op  = ALU_ADD;
        dec_cls = CLS_R;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_cls = CLS_R;
                dec_op  = arith_op;
                if (funct3 == 3'b011) begin
                    dec_ill = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) dec_op = ALU_SUB;
                    else if (funct3 != 3'b101) dec_ill = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    dec_ill = 1'b1;
                end
            end
            OPC_I: begin
                // ADDI never subtracts; only shift immediates constrain imm[11:5]
                dec_cls = CLS_I;
                dec_op  = arith_op;
                if (funct3 == 3'b011) dec_ill = 1'b1;
                else if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_ill = 1'b1;
                else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != F7_ALT) dec_ill = 1'b1;
            end
            OPC_LW: begin
                dec_cls = CLS_LW;
                dec_ill = (funct3 != 3'b010);
            end
            OPC_SW: begin
                dec_cls = CLS_SW;
                dec_ill = (funct3 != 3'b010);
            end
            OPC_BR: begin
                dec_cls = CLS_BR;
                dec_op  = ALU_SUB;
                dec_ill = (funct3[2:1] != 2'b00);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            cls_q     <= CLS_R;
            alu_op_q  <= ALU_ADD;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IF: if (mem_ready) state_d = S_ID;
            S_ID: begin
                if (dec_ill) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = S_IF;
`endif
                end else begin
                    state_d  = S_EX;
                    cls_d    = dec_cls;
                    alu_op_d = dec_op;
                end
            end
            S_EX: begin
                case (cls_q)
                    CLS_BR:         state_d = S_IF;
                    CLS_LW, CLS_SW: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: if (mem_ready) state_d = (cls_q == CLS_LW) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EX: begin
                alu_src_b = (cls_q == CLS_I) || (cls_q == CLS_LW) || (cls_q == CLS_SW);
                if (cls_q == CLS_BR) begin
                    // funct3[0] flips the sense of the compare: BEQ takes on zero, BNE on !zero
                    pc_we  = zero ^ funct3[0];
                    pc_sel = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (cls_q == CLS_SW);
                alu_src_b = 1'b1;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (cls_q == CLS_LW);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign alu_op  = alu_op_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases then random instructions with random memory stalls,
// each checked against an instruction-level phase model.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ready;
    logic        zero;
    logic [2:0]  state;
    logic        mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel, illegal;
    logic [3:0]  alu_op;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_alu;
    bit         alu_known;
    logic       exp_ill;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_LL  = 4'b1001;
    localparam logic [3:0] A_LR  = 4'b1000;
    localparam logic [3:0] A_NR  = 4'b1010;
    localparam logic [3:0] F3_ALU [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b0010,
                                           4'b1101, 4'b1000, 4'b0001, 4'b0000};

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .mem_ready (mem_ready),
        .zero      (zero),
        .state     (state),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level decode straight from the ISA subset rules
    task automatic ref_decode(input logic [31:0] i, output int kind, output logic [3:0] alu);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc  = i[6:0];
        f3   = i[14:12];
        f7   = i[31:25];
        kind = K_ILL;
        alu  = A_ADD;
        if (opc == 7'b0110011) begin
            if (f3 == 3'd3) kind = K_ILL;
            else if (f7 == 7'h00) begin kind = K_R; alu = F3_ALU[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_R; alu = A_SUB; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin kind = K_R; alu = A_NR; end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) begin kind = K_I; alu = A_LL; end
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) begin kind = K_I; alu = A_LR; end
                else if (f7 == 7'h20) begin kind = K_I; alu = A_NR; end
            end else if (f3 != 3'd3) begin
                kind = K_I; alu = F3_ALU[f3];
            end
        end else if (opc == 7'b0000011) begin
            if (f3 == 3'd2) kind = K_LW;
        end else if (opc == 7'b0100011) begin
            if (f3 == 3'd2) kind = K_SW;
        end else if (opc == 7'b1100011) begin
            if (f3 <= 3'd1) begin kind = K_BR; alu = A_SUB; end
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] f7, opc;
        logic [2:0] f3;
        logic [9:0] rs;
        logic [4:0] rd;
        int k;
        k   = $urandom_range(0, 11);
        f3  = 3'($urandom_range(0, 7));
        rs  = 10'($urandom);
        rd  = 5'($urandom);
        f7  = 7'h00;
        opc = 7'h7F;
        case (k)
            0, 1, 2: begin
                opc = 7'b0110011;
                f7  = rb() ? 7'h20 : 7'h00;
                if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
            end
            3, 4: begin
                opc = 7'b0010011;
                f7  = 7'($urandom);
                if (f3 == 3'd1) f7 = 7'h00;
                else if (f3 == 3'd5 && $urandom_range(0, 7) != 0) f7 = rb() ? 7'h20 : 7'h00;
            end
            5, 6: begin
                opc = rb() ? 7'b0000011 : 7'b0100011;
                if ($urandom_range(0, 3) != 0) f3 = 3'd2;
                f7  = 7'($urandom);
            end
            7, 8, 9: begin
                opc = 7'b1100011;
                if ($urandom_range(0, 3) != 0) f3 = {2'b00, rb()};
                f7  = 7'($urandom);
            end
            default: begin
                opc = 7'($urandom);
                f7  = 7'($urandom);
                if (opc == 7'b0010011 && f3 == 3'd1 && f7 != 7'h00) opc = 7'h7F;
            end
        endcase
        return {f7, rs, f3, rd, opc};
    endfunction

    // ctl = {mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel}
    task automatic step(input logic [2:0] st, input logic rdy, input logic z,
                        input logic [7:0] ctl, input string tag);
        mem_ready = rdy;
        zero      = z;
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'({mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel}), 32'(ctl));
        chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        if (alu_known) chk({tag, ".alu_op"}, 32'(alu_op), 32'(exp_alu));
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort(input string tag);
        mem_ready = rb();
        zero      = rb();
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        exp_alu   = A_ADD;
        alu_known = 1'b1;
        exp_ill   = 1'b0;
        #1;
        chk({tag, ".rst_state"}, 32'(state), 32'd0);
        chk({tag, ".rst_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".rst_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, ".rst_alu_op"}, 32'(alu_op), 32'(A_ADD));
        chk({tag, ".rst_illegal"}, 32'(illegal), 32'd0);
    endtask

    // abort_st: phase (0..4) in which reset is applied instead of finishing, -1 for none
    task automatic run_instr(input logic [31:0] iv, input int if_st, input int mem_st,
                             input logic z, input int abort_st, input string tag);
        int         kind;
        logic [3:0] a;
        logic [7:0] ctl;
        ref_decode(iv, kind, a);
        ir = iv;
        if (abort_st == 0) begin do_abort(tag); return; end
        for (int k = 0; k < if_st; k++) step(3'd0, 1'b0, rb(), 8'h80, {tag, ".if_wait"});
        step(3'd0, 1'b1, rb(), 8'hB0, {tag, ".if"});
        if (abort_st == 1) begin do_abort(tag); return; end
        step(3'd1, rb(), rb(), 8'h00, {tag, ".id"});
        if (kind == K_ILL) begin
            alu_known = 1'b0;
`ifdef ILLEGAL_TRAP_EN
            exp_ill = 1'b1;
            for (int k = 0; k < 3; k++) step(3'd5, rb(), rb(), 8'h00, {tag, ".halt"});
            do_abort({tag, ".halt"});
`endif
            return;
        end
        exp_alu   = a;
        alu_known = 1'b1;
        if (abort_st == 2) begin do_abort(tag); return; end
        ctl = (kind == K_I || kind == K_LW || kind == K_SW) ? 8'h04 : 8'h00;
        if (kind == K_BR) ctl = 8'h08 | ((z ^ iv[12]) ? 8'h10 : 8'h00);
        step(3'd2, rb(), z, ctl, {tag, ".ex"});
        if (kind == K_BR) return;
        if (kind == K_LW || kind == K_SW) begin
            if (abort_st == 3) begin do_abort(tag); return; end
            ctl = (kind == K_SW) ? 8'hC4 : 8'h84;
            for (int k = 0; k < mem_st; k++) step(3'd3, 1'b0, rb(), ctl, {tag, ".mem_wait"});
            step(3'd3, 1'b1, rb(), ctl, {tag, ".mem"});
            if (kind == K_SW) return;
        end
        if (abort_st == 4) begin do_abort(tag); return; end
        step(3'd4, rb(), rb(), (kind == K_LW) ? 8'h03 : 8'h02, {tag, ".wb"});
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        ir        = 32'h0;
        exp_alu   = A_ADD;
        alu_known = 1'b1;
        exp_ill   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.ctl", 32'({mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel}), 32'h80);
        chk("reset.alu_op", 32'(alu_op), 32'(A_ADD));
        chk("reset.illegal", 32'(illegal), 32'd0);
        rst = 1'b0;

        run_instr(32'h002081B3, 0, 0, rb(), -1, "add");
        run_instr(32'h402081B3, 1, 0, rb(), -1, "sub");
        run_instr(32'h4030D093, 0, 0, rb(), -1, "srai");
        run_instr(32'h00208463, 0, 0, 1'b1, -1, "beq_z1");
        run_instr(32'h00208463, 0, 0, 1'b0, -1, "beq_z0");
        run_instr(32'h00209463, 0, 0, 1'b0, -1, "bne_z0");
        run_instr(32'h0000A283, 0, 2, rb(), -1, "lw");
        run_instr(32'h0050A223, 2, 1, rb(), -1, "sw");
        run_instr(32'hFFFFFFFF, 0, 0, rb(), -1, "ill_ones");
        run_instr(32'h0020B1B3, 0, 0, rb(), -1, "ill_sltu");
        run_instr(32'h002081B3, 0, 0, rb(), -1, "add_after_ill");
        run_instr(32'h0000A283, 0, 1, rb(), 3, "lw_rst_mem");
        run_instr(32'h402081B3, 0, 0, rb(), 2, "sub_rst_ex");
        run_instr(32'h0000A283, 3, 0, rb(), 0, "lw_rst_if");

        for (int n = 0; n < 200; n++) begin
            int ab;
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 2), rb(), ab,
                      $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
